// File: rtl/shift_seq_pkg.sv
// Shared constants, op codes, FSM encoding and bit-reversal helper for shift_sequencer.
package shift_seq_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_REV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between the ALU and shift_sequencer.
interface shift_sequencer_if;
  import shift_seq_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       op;
  logic [DATA_W-1:0]     a;
  logic [SHAMT_W-1:0]    shamt;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     result;
  logic                  busy;

  modport master (
    output in_valid, op, a, shamt, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, shamt, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/reversal32.sv
// 32-bit bit-reversal datapath; passes data through unchanged when i_sel is low.
module reversal32
  import shift_seq_pkg::*;
(
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data_c
);

  always_comb begin
    o_data_c = i_data;
    if (i_sel) begin
      o_data_c = bit_reverse(i_data);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: SLL/SRL/SRA/REV via reverse + 1-bit left shifts + reverse.
// Optional build macro SHIFT_SEQ_SRA_EN enables the arithmetic fill for op SRA.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);

  state_e              r_state;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_wr;
  logic [SHAMT_W-1:0]  r_cnt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_result;

  logic                w_fill;
  logic                w_accept;
  logic                w_rev_sel;
  logic [DATA_W-1:0]   w_rev_out;
  logic [DATA_W-1:0]   w_shifted;

  assign w_accept  = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
  assign w_rev_sel = (r_state == ST_PRE) || (r_state == ST_POST);
  assign w_shifted = {r_wr[DATA_W-2:0], w_fill};

`ifdef SHIFT_SEQ_SRA_EN
  logic r_fill;

  // Sign bit captured at accept so SRA shifts in copies of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_fill <= (bus.op == OP_SRA) ? bus.a[DATA_W-1] : 1'b0;
    end
  end

  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  reversal32 u_reversal32 (
    .i_sel    (w_rev_sel),
    .i_data   (r_wr),
    .o_data_c (w_rev_out)
  );

  // FSM, working register, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_SLL;
      r_wr        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wr       <= bus.a;
            r_cnt      <= bus.shamt;
            r_op       <= op_e'(bus.op);
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
            if (bus.op == OP_SLL) begin
              if (bus.shamt == '0) begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= bus.a;
              end else begin
                r_state <= ST_SHIFT;
              end
            end else begin
              r_state <= ST_PRE;
            end
          end
        end

        ST_PRE: begin
          r_wr <= w_rev_out;
          if (r_op == OP_REV) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_rev_out;
          end else if (r_cnt != '0) begin
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_POST;
          end
        end

        ST_SHIFT: begin
          r_wr  <= w_shifted;
          r_cnt <= SHAMT_W'(r_cnt - SHAMT_W'(1));
          if (r_cnt == SHAMT_W'(1)) begin
            if (r_op == OP_SLL) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_shifted;
            end else begin
              r_state <= ST_POST;
            end
          end
        end

        ST_POST: begin
          r_wr        <= w_rev_out;
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_rev_out;
        end

        ST_DONE: begin
          // Return to IDLE only; the next accept happens one cycle later.
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_result    <= '0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;

endmodule
